// File: rtl/udc_pkg.sv
// Shared types and constants for the up/down counter sweep controller.
// Holds the FSM state encoding, the datapath widths and the config check.
package udc_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SWEEP_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } state_t;

  // A run is only meaningful with a non-empty range and at least one sweep.
  function automatic logic cfg_valid(input logic [CNT_W-1:0]   lo,
                                     input logic [CNT_W-1:0]   hi,
                                     input logic [SWEEP_W-1:0] cycles);
    return (lo < hi) && (cycles != '0);
  endfunction

endpackage

// File: rtl/updowncounter.sv
// 4-bit loadable up/down counter.
// Ports: din (load value), clk, rst (async, active-high), load (load din),
//        ud (1 = count up, 0 = count down), count (current value).
module updowncounter (
  input  logic [3:0] din,
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       ud,
  output logic [3:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= 4'd0;
    else if (load) count <= din;
    else if (ud)   count <= count + 4'd1;
    else           count <= count - 4'd1;
  end

endmodule

// File: rtl/udc_sweep_ctrl.sv
// Sweep sequencer driving one updowncounter lo->hi->lo for a programmed
// number of sweeps, with start/busy/done handshake, pause and config error.
// Ports: clk, rst (async, active-high), start, cfg_lo, cfg_hi, cfg_cycles,
//        pause; busy, done, err, dir, count (from counter), sweeps_done.
module udc_sweep_ctrl
  import udc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_lo,
  input  logic [CNT_W-1:0]   cfg_hi,
  input  logic [SWEEP_W-1:0] cfg_cycles,
  input  logic               pause,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               dir,
  output logic [CNT_W-1:0]   count,
  output logic [SWEEP_W-1:0] sweeps_done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   lo_q, hi_q;
  logic [SWEEP_W-1:0] cycles_q;
  logic [SWEEP_W-1:0] sweeps_d;
  logic [SWEEP_W-1:0] sweeps_inc;
  logic               err_d;
  logic               accept;
  logic               cnt_load;
  logic               cnt_ud;
  logic [CNT_W-1:0]   cnt_din;

  // The counter has no enable: every non-counting cycle reloads its own value.
  updowncounter u_cnt (
    .din   (cnt_din),
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .ud    (cnt_ud),
    .count (count)
  );

  assign sweeps_inc = sweeps_done + SWEEP_W'(1);

  // Next-state and counter control.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b1;
    cnt_ud   = 1'b0;
    cnt_din  = count;
    sweeps_d = sweeps_done;
    err_d    = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_valid(cfg_lo, cfg_hi, cfg_cycles)) begin
            accept   = 1'b1;
            sweeps_d = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        cnt_din = lo_q;
        state_d = UP;
      end
      UP: begin
        if (!pause) begin
          cnt_load = 1'b0;
          if (count == hi_q) begin
            cnt_ud  = 1'b0;
            state_d = DOWN;
          end else begin
            cnt_ud = 1'b1;
          end
        end
      end
      DOWN: begin
        if (!pause) begin
          if (count == lo_q) begin
            sweeps_d = sweeps_inc;
            if (sweeps_inc == cycles_q) begin
              state_d = DONE;
            end else begin
              cnt_load = 1'b0;
              cnt_ud   = 1'b1;
              state_d  = UP;
            end
          end else begin
            cnt_load = 1'b0;
            cnt_ud   = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched config and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      cycles_q    <= '0;
      sweeps_done <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dir         <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweeps_done <= sweeps_d;
      if (accept) begin
        lo_q     <= cfg_lo;
        hi_q     <= cfg_hi;
        cycles_q <= cfg_cycles;
      end
      busy <= (state_d == LOAD) || (state_d == UP) || (state_d == DOWN);
      done <= (state_d == DONE);
      err  <= err_d;
      dir  <= (state_d == UP);
    end
  end

endmodule

// File: tb/tb_udc_sweep_ctrl.sv
// Self-checking bench for udc_sweep_ctrl against a sequence-level model.
module tb_udc_sweep_ctrl;

  localparam int MAXN = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cfg_lo;
  logic [3:0] cfg_hi;
  logic [3:0] cfg_cycles;
  logic       pause;
  logic       busy;
  logic       done;
  logic       err;
  logic       dir;
  logic [3:0] count;
  logic [3:0] sweeps_done;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle observations, filled by build_model.
  int e_n;
  int e_cnt  [MAXN];
  int e_busy [MAXN];
  int e_done [MAXN];
  int e_dir  [MAXN];

  udc_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_lo      (cfg_lo),
    .cfg_hi      (cfg_hi),
    .cfg_cycles  (cfg_cycles),
    .pause       (pause),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dir         (dir),
    .count       (count),
    .sweeps_done (sweeps_done)
  );

  always #5 clk = ~clk;

  // Observation 0 is the load cycle, then the swept values (pause repeats
  // the frozen value), then the done cycle, then one idle cycle.
  function automatic void build_model(input int lo, input int hi, input int cyc,
                                      input int pk, input int plen);
    int sc[$];
    int sd[$];
    int len;
    sc.push_back(lo); sd.push_back(1);
    for (int s = 0; s < cyc; s++) begin
      for (int v = lo + 1; v <= hi; v++) begin sc.push_back(v); sd.push_back(1); end
      for (int v = hi - 1; v >= lo; v--) begin sc.push_back(v); sd.push_back(0); end
    end
    if (pk >= 1) begin
      for (int j = 0; j < plen; j++) begin
        sc.insert(pk - 1, sc[pk - 1]);
        sd.insert(pk - 1, sd[pk - 1]);
      end
    end
    len = sc.size();
    e_n = len + 3;
    e_cnt[0] = -1; e_busy[0] = 1; e_done[0] = 0; e_dir[0] = 0;
    for (int i = 0; i < len; i++) begin
      e_cnt[i+1] = sc[i]; e_busy[i+1] = 1; e_done[i+1] = 0; e_dir[i+1] = sd[i];
    end
    e_cnt[len+1] = lo; e_busy[len+1] = 0; e_done[len+1] = 1; e_dir[len+1] = 0;
    e_cnt[len+2] = lo; e_busy[len+2] = 0; e_done[len+2] = 0; e_dir[len+2] = 0;
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    cfg_lo = '0; cfg_hi = '0; cfg_cycles = '0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        dir !== 1'b0 || sweeps_done !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: count=%0d busy=%b done=%b err=%b dir=%b sweeps=%0d, want all 0",
               count, busy, done, err, dir, sweeps_done);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: count=%0d busy=%b, want 0 0", count, busy);
    end
    rst = 1'b0;
  endtask

  // Caller must be at a negedge; start is presented immediately.
  task automatic test_sweep(input string name, input int lo, input int hi, input int cyc,
                            input int pk, input int plen, input int ik);
    int nbusy;
    int want_busy;
    build_model(lo, hi, cyc, pk, plen);
    cfg_lo = 4'(lo); cfg_hi = 4'(hi); cfg_cycles = 4'(cyc);
    start = 1'b1;
    nbusy = 0;
    for (int k = 0; k < e_n; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k > 0) begin
        checks++;
        if (int'(count) !== e_cnt[k]) begin
          errors++;
          $display("FAIL %s count[%0d]: got %0d want %0d", name, k, count, e_cnt[k]);
        end
      end
      checks++;
      if (int'(busy) !== e_busy[k] || int'(done) !== e_done[k] ||
          int'(dir) !== e_dir[k] || err !== 1'b0) begin
        errors++;
        $display("FAIL %s flags[%0d]: busy=%b done=%b dir=%b err=%b want busy=%0d done=%0d dir=%0d err=0",
                 name, k, busy, done, dir, err, e_busy[k], e_done[k], e_dir[k]);
      end
      if (busy === 1'b1) nbusy++;
      pause = (pk >= 1) && (k >= pk) && (k < pk + plen);
      if (k == ik) begin
        start = 1'b1;
        cfg_lo = 4'($urandom_range(0, 7));
        cfg_hi = 4'($urandom_range(8, 15));
        cfg_cycles = 4'($urandom_range(1, 15));
      end
    end
    pause = 1'b0;
    want_busy = 2 + 2 * cyc * (hi - lo) + plen;
    checks++;
    if (nbusy != want_busy) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", name, nbusy, want_busy);
    end
    checks++;
    if (int'(sweeps_done) !== cyc) begin
      errors++;
      $display("FAIL %s sweeps_done: got %0d want %0d", name, sweeps_done, cyc);
    end
  endtask

  task automatic test_err();
    int lo_t[5]  = '{5, 9, 7, 2, 15};
    int hi_t[5]  = '{5, 3, 7, 5, 0};
    int cyc_t[5] = '{2, 1, 0, 0, 4};
    logic [3:0] prev;
    for (int i = 0; i < 5; i++) begin
      prev = count;
      cfg_lo = 4'(lo_t[i]); cfg_hi = 4'(hi_t[i]); cfg_cycles = 4'(cyc_t[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || count !== prev) begin
        errors++;
        $display("FAIL err_pulse[%0d]: err=%b busy=%b done=%b count=%0d want 1 0 0 %0d",
                 i, err, busy, done, count, prev);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || count !== prev) begin
        errors++;
        $display("FAIL err_clear[%0d]: err=%b busy=%b count=%0d want 0 0 %0d",
                 i, err, busy, count, prev);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic found = 1'b0;
    logic saw_done = 1'b0;
    cfg_lo = 4'd2; cfg_hi = 4'd5; cfg_cycles = 4'd2;
    start = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
      if (busy === 1'b1 && dir === 1'b0 && count === 4'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrun_reach: DOWN with count 3 not reached within 40 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0 || sweeps_done !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: count=%0d busy=%b done=%b dir=%b sweeps=%0d want all 0",
               count, busy, done, dir, sweeps_done);
    end
    @(negedge clk);
    if (done === 1'b1) saw_done = 1'b1;
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrun_no_done: done pulse seen, want none");
    end
    rst = 1'b0;
    test_sweep("post_reset", 1, 2, 1, 0, 0, -1);
  endtask

  task automatic test_random();
    int lo, hi, cyc, len, pk, plen;
    for (int i = 0; i < 6; i++) begin
      lo  = $urandom_range(0, 13);
      hi  = $urandom_range(lo + 1, 15);
      cyc = $urandom_range(1, 3);
      len = 1 + 2 * cyc * (hi - lo);
      if ($urandom_range(0, 1) == 1) begin
        pk = $urandom_range(1, len);
        plen = $urandom_range(1, 4);
      end else begin
        pk = 0;
        plen = 0;
      end
      test_sweep("random", lo, hi, cyc, pk, plen, -1);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_sweep("basic", 2, 5, 2, 0, 0, -1);
    test_err();
    test_sweep("full_range", 0, 15, 1, 0, 0, -1);
    test_sweep("pause", 2, 5, 2, 3, 3, -1);
    test_sweep("back_to_back", 2, 5, 2, 0, 0, 4);
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udc_sweep_ctrl.md
Name: udc_sweep_ctrl

Overview:
Sequencer for the 4-bit up/down counter (`updowncounter`: din, clk, rst, load, ud → count). It owns one counter instance and drives its load/ud/din, so the counter sweeps lo→hi→lo for a programmed number of sweeps. It provides a start/busy/done handshake, pause and a config-error flag. Intended as the control layer above the counter in the counter showcase designs.

Parameters:
CNT_W, 4, counter width; fixed to match updowncounter, no other value supported
SWEEP_W, 4, width of the sweep-count configuration and status

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset; also drives the counter instance's rst
start  in  1  single-cycle request; sampled only in IDLE
cfg_lo  in  CNT_W  sweep floor; latched on accepted start
cfg_hi  in  CNT_W  sweep ceiling; latched on accepted start
cfg_cycles  in  SWEEP_W  number of full sweeps; latched on accepted start
pause  in  1  freezes the counter and FSM while high
busy  out  1  high in LOAD, UP and DOWN states
done  out  1  one-cycle pulse on completion
err  out  1  one-cycle pulse when a start is rejected
dir  out  1  1 in UP state, 0 otherwise
count  out  CNT_W  counter value, direct from the instance
sweeps_done  out  SWEEP_W  completed sweeps in the current run

Behaviour:
- Reset (async): FSM=IDLE; counter=0; busy=done=err=dir=0; sweeps_done=0; latched config=0.
- Hold primitive: drive load=1, din=count. The counter has no enable, so every non-counting cycle uses hold.
- IDLE: drive hold.
  - start=1 with cfg_lo>=cfg_hi or cfg_cycles==0: err=1 next cycle, stay IDLE.
  - Otherwise: latch cfg, clear sweeps_done, go to LOAD.
- LOAD (1 cycle): load=1, din=lo_q. At the next edge, count=lo_q and FSM=UP.
- UP (load=0, ud=1):
  - count==hi_q: drive ud=0 this cycle, next state DOWN.
  - Otherwise count increments by 1.
- DOWN (load=0, ud=0):
  - count==lo_q: sweep complete; sweeps_done increments.
  - If the new sweeps_done==cycles_q: drive hold, go to DONE.
  - Else: drive ud=1, go to UP.
- DONE (1 cycle): done=1, hold, go to IDLE. count keeps lo_q and sweeps_done keeps its final value until the next accepted start.
- Pause in UP/DOWN: drive hold; state, sweeps_done and count are frozen. Turnaround checks are not evaluated while paused. Pause is ignored in IDLE, LOAD and DONE (LOAD always completes).
- Start while busy or in DONE is ignored. cfg_* changes after acceptance have no effect.
- Timing without pause:
  - busy is high for 2 + 2·cycles·(hi−lo) cycles.
  - count first equals lo one edge after LOAD is entered.
  - Wrap-around cannot occur, because lo<hi is enforced and the counter stays within [lo,hi].
- Reset mid-run: everything returns to reset values immediately, no done pulse. A start is accepted on the first clock after rst deasserts.

Decomposition:
- Package udc_pkg holds:
  - state enum IDLE, LOAD, UP, DOWN, DONE (3-bit encoding)
  - CNT_W and SWEEP_W constants
  - a config-validity helper (lo<hi and cycles≠0)
- Sub-module: reuse the existing updowncounter unchanged, instantiated as u_cnt. All other logic is flat FSM plus registers in udc_sweep_ctrl.

Test Plan:
- Reset, then start with lo=2, hi=5, cycles=2 → count sequence 2,3,4,5,4,3,2,3,4,5,4,3,2; busy high 14 cycles; done pulse once; sweeps_done=2; count holds 2.
- Start with lo=5, hi=5 (and separately cycles=0) → err pulses 1 cycle; busy stays 0; count unchanged.
- lo=0, hi=15, cycles=1 → reaches 15, then returns to 0 with no wrap; busy 32 cycles.
- Pause held 3 cycles while count=4 in UP → count stays 4 for 3 cycles, then resumes 5,4,…; busy extended by exactly 3 cycles.
- Assert rst while count=3 in DOWN → count=0, busy=0, no done pulse; a new start lo=1, hi=2, cycles=1 gives 1,2,1, then done.
- start pulsed again while busy, with different cfg → ignored; original sequence completes unchanged.
